fetch_unit: RTL and testbench
=============================

// Module: fetch_unit
// PURPOSE
// Instruction-fetch front end, directly upstream of the decode/ID stage. Issues word fetches
// to instruction memory over a req/gnt + rvalid interface with variable latency, buffers
// responses in a DEPTH-entry prefetch queue, and presents {pc, instruction} to decode under
// a stall (holdpc). Branch/jump redirects flush the queue and drop stale in-flight responses.
// PARAMETERS
// DEPTH            4            prefetch queue entries (power of 2, >=2)
// MAX_OUTSTANDING  2            max granted-but-unanswered imem requests (1..DEPTH)
// RESET_PC         32'h0000_0000 first fetch address after reset (bits[1:0] must be 0)
// PORTS
// clk             in   1   clock, all state updates on rising edge
// rst             in   1   synchronous, active-high reset
// imem_req        out  1   fetch request valid
// imem_addr       out  32  fetch address (word aligned)
// imem_gnt        in   1   request accepted this cycle (when imem_req=1)
// imem_rvalid     in   1   response valid; responses return in request order
// imem_rdata      in   32  fetched instruction word
// redirect_valid  in   1   branch/jump taken: restart fetch at redirect_pc
// redirect_pc     in   32  redirect target; bits[1:0] ignored (forced 0)
// holdpc          in   1   decode stall: do not consume head entry
// if_id_valid     out  1   head entry valid
// if_id_instruction out 32 head instruction
// if_id_pc_out    out  32  PC of head instruction
// BEHAVIOUR
// - One clock, clk; reset synchronous, active-high, on rst.
// - Reset: fetch_pc=RESET_PC, resp_pc=RESET_PC, queue empty, outstanding=0, drop_cnt=0;
//   outputs imem_req=0, if_id_valid=0, if_id_instruction=0, if_id_pc_out=0 in the cycle after
//   the rst edge. rst mid-operation discards queue and in-flight state.
// - imem_req (comb) = !rst_q_busy && !redirect_valid && (count+outstanding < DEPTH)
//   && (outstanding < MAX_OUTSTANDING); imem_addr = fetch_pc. On imem_req&&imem_gnt:
//   outstanding++, fetch_pc += 4 (32-bit wrap: 32'hFFFF_FFFC -> 0).
// - Credit rule (count+outstanding<DEPTH) guarantees the queue never overflows; a response is
//   always accepted. Overflow is a design error, not a handled case.
// - On imem_rvalid: outstanding--. If drop_cnt>0: drop_cnt--, data discarded. Else push
//   {resp_pc, imem_rdata}, resp_pc += 4 (same wrap rule).
// - Output: head of registered queue, if_id_valid = (count!=0). A response pushed at edge N
//   is visible on if_id_* after edge N (1-cycle rvalid-to-decode latency). Pop when
//   if_id_valid && !holdpc. Push and pop in the same cycle: count unchanged. Outputs hold
//   stable while holdpc=1. if_id_instruction/if_id_pc_out read 0 when empty.
// - Redirect (highest priority): at the edge with redirect_valid=1: queue flushed (count=0,
//   pop ignored), any same-cycle rvalid data discarded, drop_cnt = outstanding after this
//   cycle's rvalid decrement (i.e. all still in flight become stale), fetch_pc = resp_pc =
//   {redirect_pc[31:2],2'b00}. No request issued in the redirect cycle. Back-to-back
//   redirects: last one wins; drop_cnt recomputed each time.
// - imem_gnt while imem_req=0 is ignored. imem_rvalid with outstanding=0 is ignored.
// - No combinational path from imem_rdata/imem_rvalid to if_id_*.
// TESTING
// - Reset, imem zero-latency gnt, rvalid 1 cycle after gnt, holdpc=0 -> if_id_pc_out sequence
//   0,4,8,12... one per cycle at steady state, instructions match memory image.
// - holdpc=1 for 6 cycles with DEPTH=4 -> queue fills to 4, imem_req deasserts, if_id_*
//   frozen; release -> pcs continue without gap or duplicate.
// - Redirect to 32'h0000_0103 with 2 requests in flight -> both stale responses dropped,
//   next if_id_pc_out = 32'h0000_0100, queue empty in cycle after redirect.
// - Redirect coincident with rvalid and holdpc=0 pop -> rvalid data discarded, no pop
//   side-effect, drop_cnt = remaining outstanding.
// - fetch near top: redirect to 32'hFFFF_FFF8 -> pcs FFFF_FFF8, FFFF_FFFC, 0000_0000.
// - rst asserted with full queue and 2 outstanding -> next cycle if_id_valid=0, imem_req
//   from RESET_PC, late rvalids from before reset ignored (outstanding=0).

Source files
------------

// File: rtl/fetch_unit_if.sv
// Bundle between the fetch unit, instruction memory and decode.
// imem: a request transfers on a cycle with imem_req && imem_gnt; data returns in order on imem_rvalid.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        holdpc;
  logic        if_id_valid;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_out;

  modport master (
    output imem_req, imem_addr, if_id_valid, if_id_instruction, if_id_pc_out,
    input  imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, holdpc
  );

  modport slave (
    input  imem_req, imem_addr, if_id_valid, if_id_instruction, if_id_pc_out,
    output imem_gnt, imem_rvalid, imem_rdata, redirect_valid, redirect_pc, holdpc
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: credit-limited imem requests, in-order prefetch queue,
// redirect flush with stale-response dropping.
module fetch_unit #(
  parameter int          DEPTH           = 4,
  parameter int          MAX_OUTSTANDING = 2,
  parameter logic [31:0] RESET_PC        = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  fetch_unit_if.master bus
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0]   DEPTH_C   = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W-1:0] ONE_C     = CNT_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  logic [31:0]      r_fetch_pc;
  logic [31:0]      r_resp_pc;
  logic [31:0]      r_instr_q [DEPTH];
  logic [31:0]      r_pc_q    [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_outstanding;
  logic [CNT_W-1:0] r_drop_cnt;
  logic             r_rst_busy;

  logic             w_req;
  logic             w_grant;
  logic             w_resp;
  logic             w_drop;
  logic             w_push;
  logic             w_pop;
  logic             w_valid;
  logic [CNT_W:0]   w_credit;
  logic [31:0]      w_redirect_pc;

  // Queue entries plus in-flight requests never exceed DEPTH, so a response always has a slot.
  assign w_credit      = {1'b0, r_count} + {1'b0, r_outstanding};
  assign w_req         = !r_rst_busy && !bus.redirect_valid &&
                         (w_credit < DEPTH_C) && (r_outstanding < MAX_OUT_C);
  assign w_grant       = w_req && bus.imem_gnt;
  assign w_resp        = bus.imem_rvalid && (r_outstanding != '0);
  assign w_drop        = w_resp && (r_drop_cnt != '0);
  assign w_valid       = (r_count != '0);
  assign w_push        = w_resp && !w_drop && !bus.redirect_valid;
  assign w_pop         = w_valid && !bus.holdpc && !bus.redirect_valid;
  assign w_redirect_pc = bus.redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
      r_rst_busy    <= 1'b1;
    end else begin
      r_rst_busy <= 1'b0;
      case ({w_grant, w_resp})
        2'b10:   r_outstanding <= r_outstanding + ONE_C;
        2'b01:   r_outstanding <= r_outstanding - ONE_C;
        default: r_outstanding <= r_outstanding;
      endcase
      if (bus.redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        r_drop_cnt <= w_resp ? (r_outstanding - ONE_C) : r_outstanding;
        r_fetch_pc <= w_redirect_pc;
        r_resp_pc  <= w_redirect_pc;
        r_count    <= '0;
        r_rd_ptr   <= '0;
        r_wr_ptr   <= '0;
      end else begin
        if (w_grant) r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_drop)  r_drop_cnt <= r_drop_cnt - ONE_C;
        if (w_push) begin
          r_wr_ptr  <= r_wr_ptr + PTR_ONE;
          r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + ONE_C;
          2'b01:   r_count <= r_count - ONE_C;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_instr_q[r_wr_ptr] <= bus.imem_rdata;
      r_pc_q[r_wr_ptr]    <= r_resp_pc;
    end
  end

  assign bus.imem_req          = w_req;
  assign bus.imem_addr         = r_fetch_pc;
  assign bus.if_id_valid       = w_valid;
  assign bus.if_id_instruction = w_valid ? r_instr_q[r_rd_ptr] : 32'd0;
  assign bus.if_id_pc_out      = w_valid ? r_pc_q[r_rd_ptr] : 32'd0;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a queue-based model.
module tb_fetch_unit;
  localparam int DEPTH   = 4;
  localparam int MAX_OUT = 2;

  logic clk = 1'b0;
  logic rst;
  fetch_unit_if bus ();

  fetch_unit #(.DEPTH(DEPTH), .MAX_OUTSTANDING(MAX_OUT), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          armed = 1'b0;
  logic [31:0] pend_q [$];
  logic [63:0] exp_q  [$];
  logic [31:0] seen_q [$];
  logic [31:0] m_fetch_pc = 32'd0;
  logic [31:0] m_resp_pc  = 32'd0;
  int          m_out      = 0;
  int          m_drop     = 0;
  bit          m_busy     = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A3C_0F96;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: drive inputs, compare against the model, then advance model and memory.
  task automatic cycle(input bit r, input bit red, input logic [31:0] rpc,
                       input bit hold, input bit gnt, input bit rv_en);
    bit          e_valid, e_req, grant, resp;
    logic [31:0] e_pc, e_ins;
    @(negedge clk);
    rst                = r;
    bus.redirect_valid = red;
    bus.redirect_pc    = rpc;
    bus.holdpc         = hold;
    bus.imem_gnt       = gnt;
    bus.imem_rvalid    = rv_en && (pend_q.size() != 0);
    if (bus.imem_rvalid) bus.imem_rdata = mem_word(pend_q[0]);
    else                 bus.imem_rdata = $urandom;
    #1;
    e_valid = (exp_q.size() != 0);
    e_pc    = e_valid ? exp_q[0][63:32] : 32'd0;
    e_ins   = e_valid ? exp_q[0][31:0]  : 32'd0;
    e_req   = !m_busy && !red && (exp_q.size() + m_out < DEPTH) && (m_out < MAX_OUT);
    if (armed) begin
      check_eq("if_id_valid", bus.if_id_valid, e_valid);
      check_eq("if_id_pc_out", bus.if_id_pc_out, e_pc);
      check_eq("if_id_instruction", bus.if_id_instruction, e_ins);
      check_eq("imem_req", bus.imem_req, e_req);
      if (e_req) check_eq("imem_addr", bus.imem_addr, m_fetch_pc);
    end
    if (bus.if_id_valid === 1'b1 && !hold && !red && !r) seen_q.push_back(bus.if_id_pc_out);
    if (bus.imem_rvalid) void'(pend_q.pop_front());
    if (bus.imem_req === 1'b1 && gnt) pend_q.push_back(bus.imem_addr);
    grant = e_req && gnt;
    resp  = bus.imem_rvalid && (m_out > 0);
    if (r) begin
      m_fetch_pc = 32'd0; m_resp_pc = 32'd0; m_out = 0; m_drop = 0; m_busy = 1'b1;
      exp_q.delete();
    end else begin
      m_busy = 1'b0;
      if (red) begin
        exp_q.delete();
        if (resp) m_out--;
        m_drop     = m_out;
        m_fetch_pc = rpc & 32'hFFFF_FFFC;
        m_resp_pc  = rpc & 32'hFFFF_FFFC;
      end else begin
        if (e_valid && !hold) void'(exp_q.pop_front());
        if (grant) begin m_out++; m_fetch_pc += 32'd4; end
        if (resp) begin
          m_out--;
          if (m_drop > 0) m_drop--;
          else begin
            exp_q.push_back({m_resp_pc, bus.imem_rdata});
            m_resp_pc += 32'd4;
          end
        end
      end
    end
  endtask

  task automatic run_until_seen(input int n, input int budget);
    for (int i = 0; i < budget && seen_q.size() < n; i++) cycle(0, 0, 0, 0, 1, 1);
    check_eq("seen_within_budget", 32'(seen_q.size() >= n), 32'd1);
  endtask

  task automatic check_seq3(input string tag, input logic [31:0] first);
    if (seen_q.size() >= 3) begin
      check_eq({tag, "_0"}, seen_q[0], first);
      check_eq({tag, "_1"}, seen_q[1], first + 32'd4);
      check_eq({tag, "_2"}, seen_q[2], first + 32'd8);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.redirect_valid = 1'b0; bus.redirect_pc = 32'd0; bus.holdpc = 1'b0;
    bus.imem_gnt = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'd0;
    cycle(1, 0, 0, 0, 0, 0);
    armed = 1'b1;
    cycle(1, 0, 0, 0, 0, 0);

    // Streaming: zero-latency grant, one-cycle response.
    for (int i = 0; i < 14; i++) cycle(0, 0, 0, 0, 1, 1);
    check_eq("steady_rate", 32'(seen_q.size() >= 10), 32'd1);

    // Decode stall fills the queue and stops requests.
    for (int i = 0; i < 6; i++) begin
      cycle(0, 0, 0, 1, 1, 1);
      check_eq("hold_pc_frozen", bus.if_id_pc_out, 32'(4 * seen_q.size()));
    end
    check_eq("hold_req_off", bus.imem_req, 1'b0);
    check_eq("hold_valid", bus.if_id_valid, 1'b1);
    for (int i = 0; i < 10; i++) cycle(0, 0, 0, 0, 1, 1);
    check_eq("release_progress", 32'(seen_q.size() >= 20), 32'd1);
    for (int i = 0; i < seen_q.size(); i++) check_eq("seq_no_gap", seen_q[i], 32'(4 * i));

    // Redirect with two requests in flight.
    for (int i = 0; i < 8 && m_out < 2; i++) cycle(0, 0, 0, 0, 1, 0);
    check_eq("two_in_flight", 32'(pend_q.size()), 32'd2);
    cycle(0, 1, 32'h0000_0103, 0, 1, 0);
    seen_q.delete();
    cycle(0, 0, 0, 0, 1, 1);
    check_eq("redir_empty", bus.if_id_valid, 1'b0);
    run_until_seen(3, 30);
    check_seq3("redir_103", 32'h0000_0100);

    // Redirect coinciding with a response and a would-be pop.
    for (int i = 0; i < 4; i++) cycle(0, 0, 0, 0, 1, 1);
    cycle(0, 0, 0, 1, 1, 0);
    check_eq("coinc_setup", 32'(pend_q.size()), 32'd2);
    cycle(0, 1, 32'h0000_0200, 0, 1, 1);
    seen_q.delete();
    cycle(0, 0, 0, 0, 1, 1);
    check_eq("coinc_empty", bus.if_id_valid, 1'b0);
    run_until_seen(3, 30);
    check_seq3("coinc_200", 32'h0000_0200);

    // Address wrap at the top of memory.
    cycle(0, 1, 32'hFFFF_FFF8, 0, 1, 1);
    seen_q.delete();
    run_until_seen(3, 30);
    if (seen_q.size() >= 3) begin
      check_eq("wrap_0", seen_q[0], 32'hFFFF_FFF8);
      check_eq("wrap_1", seen_q[1], 32'hFFFF_FFFC);
      check_eq("wrap_2", seen_q[2], 32'h0000_0000);
    end

    // Reset with entries queued and two requests outstanding.
    for (int i = 0; i < 10 && exp_q.size() < 2; i++) cycle(0, 0, 0, 1, 1, 1);
    for (int i = 0; i < 10 && m_out < 2; i++) cycle(0, 0, 0, 1, 1, 0);
    check_eq("pre_rst_inflight", 32'(pend_q.size()), 32'd2);
    cycle(1, 0, 0, 1, 0, 0);
    cycle(0, 0, 0, 0, 0, 1);
    check_eq("rst_valid", bus.if_id_valid, 1'b0);
    check_eq("rst_req", bus.imem_req, 1'b0);
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 1);
    seen_q.delete();
    run_until_seen(3, 30);
    check_seq3("after_rst", 32'h0000_0000);
    if (seen_q.size() >= 1) check_eq("after_rst_instr_img", bus.if_id_instruction, mem_word(bus.if_id_pc_out));

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 99) < 1), ($urandom_range(0, 99) < 5), $urandom,
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 70),
            ($urandom_range(0, 99) < 60));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
